pipe_hazard_ctrl: RTL

//  Sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline registers. Detects load-use and
//  RAW hazards, branch/jump redirects and data-memory wait states. Drives hold/flush

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   - state_e   : sequencer FSM states (ST_RUN, ST_MEM_WAIT)
//   - FWD_*     : EX operand source select codes
//   - reg_match : "writer in some stage targets this source register" (x0 never matches)
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired to zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic       wr_en,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return wr_en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// pipe_hazard_ctrl_fwd_unit
//   Forwarding select for one EX-stage operand. Purely combinational.
//   Ports:
//     rs_ex         in  5  source register of the operand in EX
//     rd_mem/rd_wb  in  5  destination registers in MEM / WB
//     reg_write_mem in  1  MEM instruction writes the regfile
//     reg_write_wb  in  1  WB instruction writes the regfile
//     fwd_sel       out 2  FWD_MEM if MEM matches, else FWD_WB if WB matches, else FWD_RF
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_ex,
    input  logic [4:0] rd_mem,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_mem,
    input  logic       reg_write_wb,
    output logic [1:0] fwd_sel
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_match(reg_write_mem, rd_mem, rs_ex))
            fwd_sel = FWD_MEM;
        else if (reg_match(reg_write_wb, rd_wb, rs_ex))
            fwd_sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hold/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   Priority: data-memory wait > EX redirect > data hazard.
//   Build option: define FORWARD_EN to enable EX forwarding (only load-use stalls);
//   without it the fwd selects are tied to FWD_RF and every RAW against an EX/MEM
//   writer stalls until that writer reaches WB.
//   Ports:
//     clk, rst                          clock (rising), async active-high reset
//     rs1_id, rs2_id, rs1/rs2_used_id   ID-stage sources
//     rs1_ex, rs2_ex                    EX-stage sources
//     rd_ex/rd_mem/rd_wb, RegWrite_*    per-stage destination and write enable
//     MemRead_ex                        EX instruction is a load
//     mem_req_mem, dmem_ready           MEM data access and its completion
//     redirect_ex                       taken branch / jump resolved in EX
//     *_hold, *_flush                   pipeline register controls (combinational)
//     fwd_a_sel, fwd_b_sel              EX operand sources (combinational)
//     stall_cycles, flush_events        wrapping performance counters
//     mem_timeout                       sticky: dmem wait exceeded MEM_WAIT_MAX
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rd_mem,
    input  logic [4:0]       rd_wb,
    input  logic             RegWrite_ex,
    input  logic             RegWrite_mem,
    input  logic             RegWrite_wb,
    input  logic             MemRead_ex,
    input  logic             mem_req_mem,
    input  logic             dmem_ready,
    input  logic             redirect_ex,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              raw_ex;
    logic              data_haz;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    // The wait condition is taken straight from the inputs so the very first
    // wait cycle already freezes the pipe; the FSM only tracks wait length.
    assign mem_wait = mem_req_mem && !dmem_ready;

    assign raw_ex = (reg_match(RegWrite_ex, rd_ex, rs1_id) && rs1_used_id) ||
                    (reg_match(RegWrite_ex, rd_ex, rs2_id) && rs2_used_id);

`ifdef FORWARD_EN
    // With forwarding only a load in EX is too late to bypass.
    assign data_haz = MemRead_ex && raw_ex;

    pipe_hazard_ctrl_fwd_unit u_fwd_a (
        .rs_ex         (rs1_ex),
        .rd_mem        (rd_mem),
        .rd_wb         (rd_wb),
        .reg_write_mem (RegWrite_mem),
        .reg_write_wb  (RegWrite_wb),
        .fwd_sel       (fwd_a_raw)
    );

    pipe_hazard_ctrl_fwd_unit u_fwd_b (
        .rs_ex         (rs2_ex),
        .rd_mem        (rd_mem),
        .rd_wb         (rd_wb),
        .reg_write_mem (RegWrite_mem),
        .reg_write_wb  (RegWrite_wb),
        .fwd_sel       (fwd_b_raw)
    );
`else
    logic raw_mem;
    logic unused_nofwd;

    // No bypass: ID waits until its producer has reached WB (write-before-read RF).
    // A load-use hazard is a special case of raw_ex.
    assign raw_mem = (reg_match(RegWrite_mem, rd_mem, rs1_id) && rs1_used_id) ||
                     (reg_match(RegWrite_mem, rd_mem, rs2_id) && rs2_used_id);
    assign data_haz  = raw_ex || raw_mem;
    assign fwd_a_raw = FWD_RF;
    assign fwd_b_raw = FWD_RF;
    assign unused_nofwd = ^{rs1_ex, rs2_ex, rd_wb, RegWrite_wb, MemRead_ex};
`endif

    // Pipeline controls. Everything is forced low while reset is asserted.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        fwd_a_sel    = FWD_RF;
        fwd_b_sel    = FWD_RF;
        if (!rst) begin
            fwd_a_sel = fwd_a_raw;
            fwd_b_sel = fwd_b_raw;
            if (mem_wait) begin
                // Freeze everything up to MEM, drain a bubble into WB. A branch
                // sitting in EX is frozen too and redirects once memory is done.
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (redirect_ex) begin
                // Squashing the ID instruction makes any stall it caused moot.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (data_haz) begin
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Wait-length FSM with sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= ST_RUN;
                    end else if (wait_cnt != WAIT_W'(MEM_WAIT_MAX)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1))
                            mem_timeout <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // if_id_flush is only ever raised by a serviced redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_hold)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (if_id_flush)
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule
